// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: decodes UART RX frames into register-file / ALU strobes and pushes result bytes to the TX FIFO.
// Optional build macro SYS_CMD_TIMEOUT_EN adds an inactivity timeout to the frame-collecting states.
module sys_cmd_ctrl #(
  parameter int DW             = 8,
  parameter int REG_FILE_ADDRW = 3,
  parameter int FUNCT_W        = 4
`ifdef SYS_CMD_TIMEOUT_EN
  , parameter logic [15:0] TIMEOUT_CYCLES = 16'd20000
`endif
) (
  input  logic                      ref_clk,
  input  logic                      ref_rst,
  input  logic [DW-1:0]             RX_P_DATA,
  input  logic                      RX_D_VLD,
  output logic [REG_FILE_ADDRW-1:0] Address,
  output logic                      WrEn,
  output logic                      RdEn,
  output logic [DW-1:0]             WrData,
  input  logic [DW-1:0]             RdData,
  input  logic                      RdData_Valid,
  output logic                      ALU_EN,
  output logic [FUNCT_W-1:0]        ALU_FUN,
  output logic                      CLK_EN,
  input  logic [DW-1:0]             ALU_OUT,
  input  logic                      OUT_Valid,
  input  logic                      FIFO_FULL,
  output logic [DW-1:0]             WR_DATA,
  output logic                      WR_INC,
  output logic                      busy
);

  localparam logic [DW-1:0] CMD_WR     = DW'(8'hAA);
  localparam logic [DW-1:0] CMD_RD     = DW'(8'hBB);
  localparam logic [DW-1:0] CMD_ALU_OP = DW'(8'hCC);
  localparam logic [DW-1:0] CMD_ALU_NO = DW'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA_S, RD_ADDR, RD_WAIT,
    ALU_A, ALU_B, ALU_FN, ALU_WAIT, PUSH
  } state_t;

  state_t                    state, state_nxt;
  logic [REG_FILE_ADDRW-1:0] addr_q, addr_nxt;
  logic [REG_FILE_ADDRW-1:0] address_nxt;
  logic [DW-1:0]             wr_data_nxt, fifo_data_nxt;
  logic [FUNCT_W-1:0]        alu_fun_nxt;
  logic                      wr_en_nxt, rd_en_nxt, alu_en_nxt, clk_en_nxt;
  logic                      wr_inc_nxt, busy_nxt;
  logic                      alu_go, alu_go_nxt;

`ifdef SYS_CMD_TIMEOUT_EN
  logic [15:0] tmo_cnt, tmo_nxt;

  function automatic logic is_cmd_state(input state_t s);
    return (s == WR_ADDR) || (s == WR_DATA_S) || (s == RD_ADDR) ||
           (s == ALU_A)   || (s == ALU_B)     || (s == ALU_FN);
  endfunction
`endif

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr_q;
    address_nxt   = Address;
    wr_data_nxt   = WrData;
    fifo_data_nxt = WR_DATA;
    alu_fun_nxt   = ALU_FUN;
    clk_en_nxt    = CLK_EN;
    wr_en_nxt     = 1'b0;
    rd_en_nxt     = 1'b0;
    alu_en_nxt    = 1'b0;
    wr_inc_nxt    = 1'b0;
    alu_go_nxt    = 1'b0;
    case (state)
      IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          CMD_WR:     state_nxt = WR_ADDR;
          CMD_RD:     state_nxt = RD_ADDR;
          CMD_ALU_OP: state_nxt = ALU_A;
          CMD_ALU_NO: state_nxt = ALU_FN;
          default:    state_nxt = IDLE;
        endcase
      end
      WR_ADDR: if (RX_D_VLD) begin
        addr_nxt  = RX_P_DATA[REG_FILE_ADDRW-1:0];
        state_nxt = WR_DATA_S;
      end
      WR_DATA_S: if (RX_D_VLD) begin
        address_nxt = addr_q;
        wr_data_nxt = RX_P_DATA;
        wr_en_nxt   = 1'b1;
        state_nxt   = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        address_nxt = RX_P_DATA[REG_FILE_ADDRW-1:0];
        rd_en_nxt   = 1'b1;
        state_nxt   = RD_WAIT;
      end
      RD_WAIT: if (RdData_Valid) begin
        fifo_data_nxt = RdData;
        wr_inc_nxt    = !FIFO_FULL;
        state_nxt     = PUSH;
      end
      ALU_A: if (RX_D_VLD) begin
        address_nxt = '0;
        wr_data_nxt = RX_P_DATA;
        wr_en_nxt   = 1'b1;
        state_nxt   = ALU_B;
      end
      ALU_B: if (RX_D_VLD) begin
        address_nxt = REG_FILE_ADDRW'(1);
        wr_data_nxt = RX_P_DATA;
        wr_en_nxt   = 1'b1;
        state_nxt   = ALU_FN;
      end
      ALU_FN: if (RX_D_VLD) begin
        alu_fun_nxt = RX_P_DATA[FUNCT_W-1:0];
        clk_en_nxt  = 1'b1;
        alu_go_nxt  = 1'b1;
        state_nxt   = ALU_WAIT;
      end
      ALU_WAIT: begin
        // ALU_EN trails CLK_EN by one cycle so the gated clock is running first
        alu_en_nxt = alu_go;
        if (!alu_go && OUT_Valid) begin
          fifo_data_nxt = ALU_OUT;
          clk_en_nxt    = 1'b0;
          wr_inc_nxt    = !FIFO_FULL;
          state_nxt     = PUSH;
        end
      end
      PUSH: begin
        // Stay here for the WR_INC cycle so busy covers the push itself
        if (WR_INC)          state_nxt  = IDLE;
        else if (!FIFO_FULL) wr_inc_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef SYS_CMD_TIMEOUT_EN
    if (is_cmd_state(state) && !RX_D_VLD && (tmo_cnt == 16'd0))
      state_nxt = IDLE;
    if (!is_cmd_state(state_nxt))
      tmo_nxt = 16'd0;
    else if (RX_D_VLD || !is_cmd_state(state))
      tmo_nxt = TIMEOUT_CYCLES;
    else
      tmo_nxt = tmo_cnt - 16'd1;
`endif
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge ref_clk or negedge ref_rst) begin
    if (!ref_rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      alu_go  <= 1'b0;
      Address <= '0;
      WrEn    <= 1'b0;
      RdEn    <= 1'b0;
      WrData  <= '0;
      ALU_EN  <= 1'b0;
      ALU_FUN <= '0;
      CLK_EN  <= 1'b0;
      WR_DATA <= '0;
      WR_INC  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      alu_go  <= alu_go_nxt;
      Address <= address_nxt;
      WrEn    <= wr_en_nxt;
      RdEn    <= rd_en_nxt;
      WrData  <= wr_data_nxt;
      ALU_EN  <= alu_en_nxt;
      ALU_FUN <= alu_fun_nxt;
      CLK_EN  <= clk_en_nxt;
      WR_DATA <= fifo_data_nxt;
      WR_INC  <= wr_inc_nxt;
      busy    <= busy_nxt;
    end
  end

`ifdef SYS_CMD_TIMEOUT_EN
  always_ff @(posedge ref_clk or negedge ref_rst) begin
    if (!ref_rst) tmo_cnt <= 16'd0;
    else          tmo_cnt <= tmo_nxt;
  end
`endif

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed self-checking bench for sys_cmd_ctrl: write, read, ALU with/without operands, FIFO stall, reset abort.
module tb_sys_cmd_ctrl;
  logic       ref_clk = 1'b0;
  logic       ref_rst = 1'b0;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic [2:0] Address;
  logic       WrEn, RdEn;
  logic [7:0] WrData;
  logic [7:0] RdData = 8'h00;
  logic       RdData_Valid = 1'b0;
  logic       ALU_EN;
  logic [3:0] ALU_FUN;
  logic       CLK_EN;
  logic [7:0] ALU_OUT = 8'h00;
  logic       OUT_Valid = 1'b0;
  logic       FIFO_FULL = 1'b0;
  logic [7:0] WR_DATA;
  logic       WR_INC, busy;

  int checks = 0;
  int failures = 0;
  int wren_cnt = 0, rden_cnt = 0, aluen_cnt = 0, wrinc_cnt = 0;

  always #5 ref_clk = ~ref_clk;

  sys_cmd_ctrl #(
    .DW(8), .REG_FILE_ADDRW(3), .FUNCT_W(4)
`ifdef SYS_CMD_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16'd100)
`endif
  ) dut (
    .ref_clk(ref_clk), .ref_rst(ref_rst),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
    .RdData(RdData), .RdData_Valid(RdData_Valid),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
    .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
    .FIFO_FULL(FIFO_FULL), .WR_DATA(WR_DATA), .WR_INC(WR_INC), .busy(busy)
  );

  // Pulse counters sampled shortly after each active edge
  always @(posedge ref_clk) begin
    #2;
    if (WrEn)   wren_cnt++;
    if (RdEn)   rden_cnt++;
    if (ALU_EN) aluen_cnt++;
    if (WR_INC) wrinc_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge ref_clk);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge ref_clk);
    RX_D_VLD  = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge ref_clk);
    chk("rst_busy", busy, 0);
    chk("rst_wren", WrEn, 0);
    chk("rst_clken", CLK_EN, 0);
    chk("rst_wrinc", WR_INC, 0);
    chk("rst_addr", Address, 0);
    ref_rst = 1'b1;

    // Write AA,06,FF
    send(8'hAA);
    chk("wr_busy", busy, 1);
    send(8'h06);
    send(8'hFF);
    chk("wr_en", WrEn, 1);
    chk("wr_addr", Address, 3'd6);
    chk("wr_data", WrData, 8'hFF);
    chk("wr_busy_end", busy, 0);
    @(negedge ref_clk);
    chk("wr_en_drop", WrEn, 0);
    chk("wr_no_push", wrinc_cnt, 0);

    // Stray read-data valid in IDLE is ignored
    RdData = 8'h33; RdData_Valid = 1'b1;
    @(negedge ref_clk);
    RdData_Valid = 1'b0;
    chk("idle_rdvld", WR_INC, 0);

    // Read BB,06 with data two cycles after RdEn
    send(8'hBB);
    send(8'h06);
    chk("rd_en", RdEn, 1);
    chk("rd_addr", Address, 3'd6);
    @(negedge ref_clk);
    chk("rd_en_drop", RdEn, 0);
    RdData = 8'hFF; RdData_Valid = 1'b1;
    @(negedge ref_clk);
    RdData_Valid = 1'b0;
    chk("rd_wrinc", WR_INC, 1);
    chk("rd_wrdata", WR_DATA, 8'hFF);
    chk("rd_busy", busy, 1);
    @(negedge ref_clk);
    chk("rd_wrinc_drop", WR_INC, 0);
    chk("rd_busy_end", busy, 0);

    // ALU with operands CC,03,06,02
    send(8'hCC);
    send(8'h03);
    chk("aluA_wren", WrEn, 1);
    chk("aluA_addr", Address, 0);
    chk("aluA_data", WrData, 8'h03);
    send(8'h06);
    chk("aluB_wren", WrEn, 1);
    chk("aluB_addr", Address, 1);
    chk("aluB_data", WrData, 8'h06);
    send(8'h02);
    chk("alu_clken", CLK_EN, 1);
    chk("alu_en_early", ALU_EN, 0);
    chk("alu_fun", ALU_FUN, 4'd2);
    @(negedge ref_clk);
    chk("alu_en", ALU_EN, 1);
    @(negedge ref_clk);
    chk("alu_en_drop", ALU_EN, 0);
    chk("alu_clken_hold", CLK_EN, 1);
    ALU_OUT = 8'd18; OUT_Valid = 1'b1;
    @(negedge ref_clk);
    OUT_Valid = 1'b0;
    chk("alu_clken_off", CLK_EN, 0);
    chk("alu_wrinc", WR_INC, 1);
    chk("alu_wrdata", WR_DATA, 8'd18);
    @(negedge ref_clk);

    // ALU without operands DD,04 with FIFO full for 10 cycles
    send(8'hDD);
    send(8'h04);
    chk("full_clken", CLK_EN, 1);
    @(negedge ref_clk);
    chk("full_alu_en", ALU_EN, 1);
    ALU_OUT = 8'h02; OUT_Valid = 1'b1; FIFO_FULL = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ref_clk);
      OUT_Valid = 1'b0;
      chk("full_hold", WR_INC, 0);
      if (i == 9) FIFO_FULL = 1'b0;
    end
    @(negedge ref_clk);
    chk("full_wrinc", WR_INC, 1);
    chk("full_wrdata", WR_DATA, 8'h02);
    chk("full_busy", busy, 1);
    @(negedge ref_clk);
    chk("full_wrinc_drop", WR_INC, 0);
    chk("full_busy_end", busy, 0);

    // Unknown frame, then reset during ALU_WAIT
    send(8'h55);
    chk("bad_busy", busy, 0);
    @(negedge ref_clk);
    chk("bad_busy2", busy, 0);
    send(8'hDD);
    send(8'h01);
    chk("abort_clken_pre", CLK_EN, 1);
    #2 ref_rst = 1'b0;
    #1;
    chk("abort_clken", CLK_EN, 0);
    chk("abort_busy", busy, 0);
    @(negedge ref_clk);
    ref_rst = 1'b1;
    send(8'hAA);
    send(8'h07);
    send(8'hFF);
    chk("post_wren", WrEn, 1);
    chk("post_addr", Address, 3'd7);
    chk("post_data", WrData, 8'hFF);

`ifdef SYS_CMD_TIMEOUT_EN
    // Timeout: AA,05 then silence
    send(8'hAA);
    send(8'h05);
    repeat (105) @(negedge ref_clk);
    chk("tmo_busy", busy, 0);
    send(8'hFF);
    chk("tmo_no_wren", WrEn, 0);
    @(negedge ref_clk);
`endif

    @(negedge ref_clk);
    chk("tot_wren", wren_cnt, 4);
    chk("tot_rden", rden_cnt, 1);
    chk("tot_aluen", aluen_cnt, 2);
    chk("tot_wrinc", wrinc_cnt, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
